// File: rtl/crc_frame_serializer.sv
// Serializes valid/ready frame words LSB-first onto Data/ACTIVE, then gathers the serial CRC returned.
// Latency: first bit one cycle after accept; CRC_Value/Frame_Done one cycle after the last CRC bit.
// Backpressure: In_Ready high in IDLE and on the final bit of a non-last word only (gapless chaining).
module crc_frame_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int CRC_WIDTH  = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] In_Data,
  input  logic                  In_Valid,
  input  logic                  In_Last,
  output logic                  In_Ready,
  output logic                  Data,
  output logic                  ACTIVE,
  input  logic                  CRC_In,
  input  logic                  CRC_Valid,
  output logic [CRC_WIDTH-1:0]  CRC_Value,
  output logic [7:0]            Byte_Count,
  output logic                  Busy,
  output logic                  Frame_Done,
  output logic                  Underrun_Err,
  output logic                  Timeout_Err
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int CCW = (CRC_WIDTH > 1) ? $clog2(CRC_WIDTH) : 1;
  localparam int TCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CRC_WAIT} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  last_q, last_d;
  logic [7:0]            byte_cnt_q, byte_cnt_d;
  logic [CRC_WIDTH-1:0]  crc_val_q, crc_val_d;
  logic [CCW-1:0]        crc_cnt_q, crc_cnt_d;
  logic [TCW-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic [TCW-1:0]        tmo_inc;
  logic                  data_q, data_d;
  logic                  active_q, active_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  underrun_q, underrun_d;
  logic                  timeout_q, timeout_d;
  logic                  last_bit;
  logic                  accept;

  assign last_bit = (bit_cnt_q == BCW'(DATA_WIDTH - 1));
  // Ready only decodes state: idle, or final bit of a word that is not the frame's last
  assign In_Ready = (state_q == IDLE) || ((state_q == SHIFT) && last_bit && !last_q);
  assign accept   = In_Valid && In_Ready;
  assign tmo_inc  = tmo_cnt_q + TCW'(1);

  // Next-state and next-output computation for the serializer FSM
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    last_d     = last_q;
    byte_cnt_d = byte_cnt_q;
    crc_val_d  = crc_val_q;
    crc_cnt_d  = crc_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    data_d     = data_q;
    active_d   = active_q;
    underrun_d = underrun_q;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = SHIFT;
          shreg_d    = In_Data >> 1;
          data_d     = In_Data[0];
          active_d   = 1'b1;
          last_d     = In_Last;
          bit_cnt_d  = '0;
          byte_cnt_d = 8'd1;
          crc_val_d  = '0;
          crc_cnt_d  = '0;
          tmo_cnt_d  = '0;
          underrun_d = 1'b0;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          data_d    = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end else if (accept) begin
          // Chained word: its bit 0 follows the previous bit 7 with no gap
          shreg_d   = In_Data >> 1;
          data_d    = In_Data[0];
          last_d    = In_Last;
          bit_cnt_d = '0;
          if (byte_cnt_q != 8'hFF) byte_cnt_d = byte_cnt_q + 8'd1;
        end else begin
          // Either a clean end of frame or a missing word; both close the frame
          state_d   = CRC_WAIT;
          active_d  = 1'b0;
          data_d    = 1'b0;
          tmo_cnt_d = '0;
          if (!last_q) underrun_d = 1'b1;
        end
      end
      CRC_WAIT: begin
        if (CRC_Valid) begin
          // A valid bit always beats a coincident timeout
          crc_val_d[crc_cnt_q] = CRC_In;
          crc_cnt_d            = crc_cnt_q + CCW'(1);
          tmo_cnt_d            = '0;
          if (crc_cnt_q == CCW'(CRC_WIDTH - 1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          tmo_cnt_d = tmo_inc;
          if (tmo_inc == TCW'(TIMEOUT)) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any frame without pulses
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      last_q     <= 1'b0;
      byte_cnt_q <= '0;
      crc_val_q  <= '0;
      crc_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      data_q     <= 1'b0;
      active_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      last_q     <= last_d;
      byte_cnt_q <= byte_cnt_d;
      crc_val_q  <= crc_val_d;
      crc_cnt_q  <= crc_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      data_q     <= data_d;
      active_q   <= active_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign Data         = data_q;
  assign ACTIVE       = active_q;
  assign CRC_Value    = crc_val_q;
  assign Byte_Count   = byte_cnt_q;
  assign Busy         = busy_q;
  assign Frame_Done   = done_q;
  assign Underrun_Err = underrun_q;
  assign Timeout_Err  = timeout_q;

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Directed bench for crc_frame_serializer: serialization, chaining, underrun, timeout, reset, saturation.
// Inputs change 1ns after the rising edge; outputs are observed at the same point.
// A CRC-8 (x^8+x^2+x+1) serial model plays the part of the engine.
module tb_crc_frame_serializer;

  localparam int DW = 8;
  localparam int CW = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] In_Data = '0;
  logic       In_Valid = 1'b0;
  logic       In_Last = 1'b0;
  logic       In_Ready;
  logic       Data;
  logic       ACTIVE;
  logic       CRC_In = 1'b0;
  logic       CRC_Valid = 1'b0;
  logic [7:0] CRC_Value;
  logic [7:0] Byte_Count;
  logic       Busy;
  logic       Frame_Done;
  logic       Underrun_Err;
  logic       Timeout_Err;

  int checks = 0;
  int failures = 0;
  int active_cycles = 0;
  logic [7:0] frame_mem [0:299];

  crc_frame_serializer #(.DATA_WIDTH(DW), .CRC_WIDTH(CW), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST), .In_Data(In_Data), .In_Valid(In_Valid), .In_Last(In_Last),
    .In_Ready(In_Ready), .Data(Data), .ACTIVE(ACTIVE), .CRC_In(CRC_In), .CRC_Valid(CRC_Valid),
    .CRC_Value(CRC_Value), .Byte_Count(Byte_Count), .Busy(Busy), .Frame_Done(Frame_Done),
    .Underrun_Err(Underrun_Err), .Timeout_Err(Timeout_Err)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Engine model: serial CRC-8 over the first n frame bytes, LSB first
  function automatic logic [7:0] golden_crc(input int n);
    logic [7:0] c;
    logic       fb;
    c = '0;
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < DW; k++) begin
        fb = c[7] ^ frame_mem[j][k];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  // Streams n bytes from frame_mem with In_Valid held; last_final sets In_Last on the final byte
  task automatic send_bytes(input int n, input bit last_final, input bit crc_noise, input string nm);
    logic       exp_rdy;
    logic [7:0] exp_cnt;
    In_Data  = frame_mem[0];
    In_Valid = 1'b1;
    In_Last  = (n == 1) && last_final;
    CRC_Valid = crc_noise;
    CRC_In    = crc_noise;
    checks++; if (In_Ready !== 1'b1) begin failures++; $display("FAIL %s idle_ready got=%b exp=1", nm, In_Ready); end
    for (int j = 0; j < n; j++) begin
      tick;
      if (j + 1 < n) begin
        In_Data = frame_mem[j+1]; In_Valid = 1'b1; In_Last = (j + 1 == n - 1) && last_final;
      end else begin
        In_Data = '0; In_Valid = 1'b0; In_Last = 1'b0;
      end
      for (int k = 0; k < DW; k++) begin
        if (k > 0) tick;
        if (ACTIVE === 1'b1) active_cycles++;
        checks++; if (ACTIVE !== 1'b1 || Data !== frame_mem[j][k]) begin failures++; $display("FAIL %s bit byte=%0d k=%0d got active=%b data=%b exp active=1 data=%b", nm, j, k, ACTIVE, Data, frame_mem[j][k]); end
        exp_rdy = (k == DW - 1) && !((j == n - 1) && last_final);
        checks++; if (In_Ready !== exp_rdy) begin failures++; $display("FAIL %s shift_ready byte=%0d k=%0d got=%b exp=%b", nm, j, k, In_Ready, exp_rdy); end
        if (j == 0 && k == 0) begin
          checks++; if (Underrun_Err !== 1'b0 || Busy !== 1'b1) begin failures++; $display("FAIL %s start_flags got underrun=%b busy=%b exp 0 1", nm, Underrun_Err, Busy); end
        end
      end
    end
    tick;
    CRC_Valid = 1'b0;
    CRC_In    = 1'b0;
    exp_cnt = (n > 255) ? 8'd255 : n[7:0];
    checks++; if (ACTIVE !== 1'b0 || Data !== 1'b0 || Busy !== 1'b1 || In_Ready !== 1'b0) begin failures++; $display("FAIL %s crc_wait_entry got active=%b data=%b busy=%b rdy=%b exp 0 0 1 0", nm, ACTIVE, Data, Busy, In_Ready); end
    checks++; if (Underrun_Err !== !last_final) begin failures++; $display("FAIL %s underrun got=%b exp=%b", nm, Underrun_Err, !last_final); end
    checks++; if (Byte_Count !== exp_cnt) begin failures++; $display("FAIL %s byte_count got=%0d exp=%0d", nm, Byte_Count, exp_cnt); end
  endtask

  // Returns CW CRC bits back-to-back and checks the collected value and done pulse
  task automatic crc_phase(input logic [7:0] crc, input string nm);
    for (int i = 0; i < CW; i++) begin
      CRC_Valid = 1'b1;
      CRC_In    = crc[i];
      tick;
      if (i < CW - 1) begin
        checks++; if (Frame_Done !== 1'b0 || Busy !== 1'b1) begin failures++; $display("FAIL %s early_done i=%0d got done=%b busy=%b exp 0 1", nm, i, Frame_Done, Busy); end
      end
    end
    CRC_Valid = 1'b0;
    CRC_In    = 1'b0;
    checks++; if (Frame_Done !== 1'b1 || Busy !== 1'b0 || In_Ready !== 1'b1) begin failures++; $display("FAIL %s done got done=%b busy=%b rdy=%b exp 1 0 1", nm, Frame_Done, Busy, In_Ready); end
    checks++; if (CRC_Value !== crc) begin failures++; $display("FAIL %s crc_value got=%h exp=%h", nm, CRC_Value, crc); end
    tick;
    checks++; if (Frame_Done !== 1'b0 || CRC_Value !== crc) begin failures++; $display("FAIL %s done_pulse_hold got done=%b crc=%h exp 0 %h", nm, Frame_Done, CRC_Value, crc); end
  endtask

  task automatic test_reset;
    RST = 1'b0;
    tick; tick;
    checks++; if (In_Ready !== 1'b1 || ACTIVE !== 1'b0 || Data !== 1'b0 || Busy !== 1'b0) begin failures++; $display("FAIL reset_ctl got rdy=%b active=%b data=%b busy=%b exp 1 0 0 0", In_Ready, ACTIVE, Data, Busy); end
    checks++; if (CRC_Value !== 8'h00 || Byte_Count !== 8'h00) begin failures++; $display("FAIL reset_regs got crc=%h cnt=%h exp 00 00", CRC_Value, Byte_Count); end
    checks++; if (Frame_Done !== 1'b0 || Underrun_Err !== 1'b0 || Timeout_Err !== 1'b0) begin failures++; $display("FAIL reset_flags got done=%b und=%b tmo=%b exp 0 0 0", Frame_Done, Underrun_Err, Timeout_Err); end
    RST = 1'b1;
    tick;
    checks++; if (In_Ready !== 1'b1 || Busy !== 1'b0) begin failures++; $display("FAIL reset_release got rdy=%b busy=%b exp 1 0", In_Ready, Busy); end
  endtask

  task automatic test_single_byte;
    frame_mem[0] = 8'hA5;
    active_cycles = 0;
    send_bytes(1, 1'b1, 1'b1, "single");
    checks++; if (active_cycles != 8) begin failures++; $display("FAIL single active_cycles got=%0d exp=8", active_cycles); end
    crc_phase(golden_crc(1), "single");
  endtask

  task automatic test_back_to_back;
    frame_mem[0] = 8'h01; frame_mem[1] = 8'h02; frame_mem[2] = 8'h03;
    active_cycles = 0;
    send_bytes(3, 1'b1, 1'b0, "b2b");
    checks++; if (active_cycles != 24) begin failures++; $display("FAIL b2b active_cycles got=%0d exp=24", active_cycles); end
    crc_phase(golden_crc(3), "b2b");
  endtask

  task automatic test_underrun;
    frame_mem[0] = 8'h55;
    send_bytes(1, 1'b0, 1'b0, "underrun");
    crc_phase(golden_crc(1), "underrun");
    checks++; if (Underrun_Err !== 1'b1) begin failures++; $display("FAIL underrun_sticky got=%b exp=1", Underrun_Err); end
  endtask

  task automatic test_timeout;
    frame_mem[0] = 8'h3C;
    send_bytes(1, 1'b1, 1'b0, "timeout");
    for (int c = 1; c < 16; c++) begin
      tick;
      checks++; if (Timeout_Err !== 1'b0 || Busy !== 1'b1) begin failures++; $display("FAIL timeout_early c=%0d got tmo=%b busy=%b exp 0 1", c, Timeout_Err, Busy); end
    end
    tick;
    checks++; if (Timeout_Err !== 1'b1 || Busy !== 1'b0 || In_Ready !== 1'b1) begin failures++; $display("FAIL timeout_fire got tmo=%b busy=%b rdy=%b exp 1 0 1", Timeout_Err, Busy, In_Ready); end
    checks++; if (CRC_Value !== 8'h00 || Frame_Done !== 1'b0) begin failures++; $display("FAIL timeout_crc got crc=%h done=%b exp 00 0", CRC_Value, Frame_Done); end
    tick;
    checks++; if (Timeout_Err !== 1'b0) begin failures++; $display("FAIL timeout_pulse got=%b exp=0", Timeout_Err); end
  endtask

  task automatic test_timeout_edge;
    frame_mem[0] = 8'hC3;
    send_bytes(1, 1'b1, 1'b0, "tmo_edge");
    for (int c = 1; c < 16; c++) tick;
    CRC_Valid = 1'b1;
    CRC_In    = 1'b1;
    tick;
    checks++; if (Timeout_Err !== 1'b0 || Busy !== 1'b1 || CRC_Value !== 8'h01) begin failures++; $display("FAIL tmo_edge got tmo=%b busy=%b crc=%h exp 0 1 01", Timeout_Err, Busy, CRC_Value); end
    CRC_In = 1'b0;
    for (int i = 1; i < CW; i++) tick;
    CRC_Valid = 1'b0;
    checks++; if (Frame_Done !== 1'b1 || CRC_Value !== 8'h01 || Timeout_Err !== 1'b0) begin failures++; $display("FAIL tmo_edge_done got done=%b crc=%h tmo=%b exp 1 01 0", Frame_Done, CRC_Value, Timeout_Err); end
    tick;
  endtask

  task automatic test_reset_mid;
    frame_mem[0] = 8'hF0;
    In_Data = 8'hF0; In_Valid = 1'b1; In_Last = 1'b1;
    tick;
    In_Valid = 1'b0; In_Last = 1'b0;
    for (int k = 1; k <= 4; k++) tick;
    checks++; if (ACTIVE !== 1'b1 || Data !== 1'b1) begin failures++; $display("FAIL rst_mid_bit4 got active=%b data=%b exp 1 1", ACTIVE, Data); end
    RST = 1'b0;
    #1;
    checks++; if (ACTIVE !== 1'b0 || Data !== 1'b0 || Busy !== 1'b0 || In_Ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ctl got active=%b data=%b busy=%b rdy=%b exp 0 0 0 1", ACTIVE, Data, Busy, In_Ready); end
    checks++; if (Byte_Count !== 8'h00 || CRC_Value !== 8'h00) begin failures++; $display("FAIL rst_mid_regs got cnt=%h crc=%h exp 00 00", Byte_Count, CRC_Value); end
    tick; tick;
    RST = 1'b1;
    CRC_Valid = 1'b1; CRC_In = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick;
      checks++; if (Frame_Done !== 1'b0 || Busy !== 1'b0 || CRC_Value !== 8'h00) begin failures++; $display("FAIL rst_mid_idle c=%0d got done=%b busy=%b crc=%h exp 0 0 00", c, Frame_Done, Busy, CRC_Value); end
    end
    CRC_Valid = 1'b0; CRC_In = 1'b0;
    frame_mem[0] = 8'h9E; frame_mem[1] = 8'h47;
    send_bytes(2, 1'b1, 1'b0, "rst_next");
    crc_phase(golden_crc(2), "rst_next");
  endtask

  task automatic test_saturate;
    for (int j = 0; j < 300; j++) frame_mem[j] = 8'((j * 7) + 3);
    active_cycles = 0;
    send_bytes(300, 1'b1, 1'b0, "sat");
    checks++; if (active_cycles != 2400) begin failures++; $display("FAIL sat active_cycles got=%0d exp=2400", active_cycles); end
    crc_phase(golden_crc(300), "sat");
    checks++; if (Byte_Count !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d exp=255", Byte_Count); end
  endtask

  initial begin
    test_reset;
    test_single_byte;
    test_back_to_back;
    test_underrun;
    test_timeout;
    test_timeout_edge;
    test_reset_mid;
    test_saturate;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
